voq_bank: RTL and testbench

//  Per-egress-port virtual output queues holding frame start pointers (SRAM block indices).

---
 rtl/voq_bank_if.sv | 34 +++
 rtl/voq_bank.sv | 129 ++++++++++++
 tb/tb_voq_bank.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/voq_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : voq_bank_if
// Brief    : Crossbar-side enqueue bus and read-controller head/status bundle
//            for the virtual output queue bank.
// Revision : 1.0
// ============================================================================
interface voq_bank_if #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 10,
   parameter int CNT_W     = 5,
   parameter int DROP_W    = 16
);
   logic [NUM_PORTS-1:0]             voq_write_reqs;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] voq_start_ptrs;
   logic [NUM_PORTS-1:0]             head_valid;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] head_ptr;
   logic [NUM_PORTS-1:0]             head_ready;
   logic [NUM_PORTS-1:0][CNT_W-1:0]  count;
   logic [NUM_PORTS-1:0]             almost_full;
   logic [NUM_PORTS-1:0][DROP_W-1:0] drop_cnt;

   // Master is the crossbar plus read controllers; slave is the queue bank.
   modport master (
      output voq_write_reqs, voq_start_ptrs, head_ready,
      input  head_valid, head_ptr, count, almost_full, drop_cnt
   );

   modport slave (
      input  voq_write_reqs, voq_start_ptrs, head_ready,
      output head_valid, head_ptr, count, almost_full, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/voq_bank.sv
`default_nettype none
// ============================================================================
// Module   : voq_bank
// Brief    : Per-egress-port FWFT virtual output queues of frame start
//            pointers with drop counting, occupancy and almost-full status.
// Revision : 1.0
// ============================================================================
module voq_bank #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 16,
   parameter int AF_LEVEL  = 12,
   parameter int DROP_W    = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   voq_bank_if.slave voq_io
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0]  c_full     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  c_af       = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
   localparam logic [PTR_W-1:0]  c_ptr_one  = PTR_W'(1);
   localparam logic [DROP_W-1:0] c_drop_one = DROP_W'(1);
   localparam logic [DROP_W-1:0] c_drop_max = '1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("voq_bank: DEPTH must be a power of 2 and at least 2");
   end

   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
      $error("voq_bank: AF_LEVEL must lie in 1..DEPTH");
   end

   logic [ADDR_W-1:0] mem_q      [NUM_PORTS][DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q   [NUM_PORTS];
   logic [PTR_W-1:0]  wr_ptr_d   [NUM_PORTS];
   logic [PTR_W-1:0]  rd_ptr_q   [NUM_PORTS];
   logic [PTR_W-1:0]  rd_ptr_d   [NUM_PORTS];
   logic [CNT_W-1:0]  cnt_q      [NUM_PORTS];
   logic [CNT_W-1:0]  cnt_d      [NUM_PORTS];
   logic [DROP_W-1:0] drop_cnt_q [NUM_PORTS];
   logic [DROP_W-1:0] drop_cnt_d [NUM_PORTS];

   logic [NUM_PORTS-1:0] w_pop;
   logic [NUM_PORTS-1:0] w_push;
   logic [NUM_PORTS-1:0] w_drop;

   // A full queue still accepts a push when its head leaves in the same cycle.
   always_comb begin
      w_pop  = '0;
      w_push = '0;
      w_drop = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_pop[p]  = (cnt_q[p] != '0) && voq_io.head_ready[p];
         w_push[p] = voq_io.voq_write_reqs[p] && ((cnt_q[p] != c_full) || w_pop[p]);
         w_drop[p] = voq_io.voq_write_reqs[p] && (cnt_q[p] == c_full) && !w_pop[p];
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         wr_ptr_d[p]   = wr_ptr_q[p];
         rd_ptr_d[p]   = rd_ptr_q[p];
         cnt_d[p]      = cnt_q[p];
         drop_cnt_d[p] = drop_cnt_q[p];

         if (w_push[p]) begin
            wr_ptr_d[p] = wr_ptr_q[p] + c_ptr_one;
         end
         if (w_pop[p]) begin
            rd_ptr_d[p] = rd_ptr_q[p] + c_ptr_one;
         end
         if (w_push[p] && !w_pop[p]) begin
            cnt_d[p] = cnt_q[p] + c_cnt_one;
         end else if (w_pop[p] && !w_push[p]) begin
            cnt_d[p] = cnt_q[p] - c_cnt_one;
         end
         if (w_drop[p] && (drop_cnt_q[p] != c_drop_max)) begin
            drop_cnt_d[p] = drop_cnt_q[p] + c_drop_one;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_q[p]   <= '0;
            rd_ptr_q[p]   <= '0;
            cnt_q[p]      <= '0;
            drop_cnt_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_q[p]   <= wr_ptr_d[p];
            rd_ptr_q[p]   <= rd_ptr_d[p];
            cnt_q[p]      <= cnt_d[p];
            drop_cnt_q[p] <= drop_cnt_d[p];
         end
      end
   end

   // Pointer storage carries no reset; head_valid masks stale contents.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_push[p]) begin
            mem_q[p][wr_ptr_q[p]] <= voq_io.voq_start_ptrs[p];
         end
      end
   end

   always_comb begin
      voq_io.head_valid  = '0;
      voq_io.head_ptr    = '0;
      voq_io.count       = '0;
      voq_io.almost_full = '0;
      voq_io.drop_cnt    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         voq_io.head_valid[p]  = (cnt_q[p] != '0);
         voq_io.head_ptr[p]    = mem_q[p][rd_ptr_q[p]];
         voq_io.count[p]       = cnt_q[p];
         voq_io.almost_full[p] = (cnt_q[p] >= c_af);
         voq_io.drop_cnt[p]    = drop_cnt_q[p];
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_voq_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_voq_bank
// Brief    : Self-checking bench for voq_bank against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_voq_bank;
   localparam int NP    = 4;
   localparam int AW    = 10;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;
   localparam int DW    = 4;
   localparam int CW    = 5;
   localparam int DMAX  = (1 << DW) - 1;

   logic clk;
   logic rst_n;

   voq_bank_if #(.NUM_PORTS(NP), .ADDR_W(AW), .CNT_W(CW), .DROP_W(DW)) io ();

   voq_bank #(
      .NUM_PORTS(NP),
      .ADDR_W   (AW),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AFL),
      .DROP_W   (DW)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .voq_io(io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] mq [NP][$];
   int            mdrop [NP];
   int            n_assert;
   int            n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int p = 0; p < NP; p++) begin
         check($sformatf("%s_valid%0d", tag, p), 32'(io.head_valid[p]), 32'(mq[p].size() > 0));
         check($sformatf("%s_count%0d", tag, p), 32'(io.count[p]), 32'(mq[p].size()));
         check($sformatf("%s_af%0d", tag, p), 32'(io.almost_full[p]), 32'(mq[p].size() >= AFL));
         check($sformatf("%s_drop%0d", tag, p), 32'(io.drop_cnt[p]), 32'(mdrop[p]));
         if (mq[p].size() > 0)
            check($sformatf("%s_head%0d", tag, p), 32'(io.head_ptr[p]), 32'(mq[p][0]));
      end
   endtask

   task automatic model_clear();
      for (int p = 0; p < NP; p++) begin
         mq[p].delete();
         mdrop[p] = 0;
      end
   endtask

   // One clock of traffic: drive at negedge, advance model at posedge, check after.
   task automatic step(input string tag, input logic [NP-1:0] req,
                       input logic [NP-1:0][AW-1:0] ptrs, input logic [NP-1:0] rdy);
      bit do_pop [NP];
      bit do_push [NP];
      @(negedge clk);
      io.voq_write_reqs = req;
      io.voq_start_ptrs = ptrs;
      io.head_ready     = rdy;
      for (int p = 0; p < NP; p++) begin
         do_pop[p]  = (mq[p].size() > 0) && rdy[p];
         do_push[p] = req[p] && ((mq[p].size() < DEPTH) || do_pop[p]);
         if (req[p] && !do_push[p] && mdrop[p] < DMAX) mdrop[p]++;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (do_pop[p]) void'(mq[p].pop_front());
         if (do_push[p]) mq[p].push_back(ptrs[p]);
      end
      check_all(tag);
   endtask

   task automatic push_one(input string tag, input int p, input logic [AW-1:0] v,
                           input logic [NP-1:0] rdy);
      logic [NP-1:0][AW-1:0] ptrs;
      logic [NP-1:0]         req;
      ptrs    = '0;
      ptrs[p] = v;
      req     = '0;
      req[p]  = 1'b1;
      step(tag, req, ptrs, rdy);
   endtask

   task automatic idle(input string tag, input logic [NP-1:0] rdy);
      step(tag, '0, '0, rdy);
   endtask

   initial begin
      logic [NP-1:0][AW-1:0] ptrs;
      logic [NP-1:0]         req;
      logic [NP-1:0]         rdy;
      n_assert = 0;
      n_fail   = 0;
      model_clear();
      io.voq_write_reqs = '0;
      io.voq_start_ptrs = '0;
      io.head_ready     = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single push reaches the head on the following cycle
      push_one("t1", 0, 10'h011, 4'b0000);
      check("t1_head0", 32'(io.head_ptr[0]), 32'h011);
      idle("t1_drain", 4'b0001);

      // 2: fill q2, overflow once, then drain in order
      for (int i = 1; i <= 16; i++) begin
         push_one("t2_fill", 2, AW'(i), 4'b0000);
         check("t2_af", 32'(io.almost_full[2]), 32'(i >= 12));
      end
      push_one("t2_over", 2, 10'h0FF, 4'b0000);
      check("t2_drop", 32'(io.drop_cnt[2]), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         check("t2_order", 32'(io.head_ptr[2]), 32'(i));
         idle("t2_drain", 4'b0100);
      end

      // 3: push into a full queue while its head leaves
      for (int i = 0; i < 16; i++) push_one("t3_fill", 1, AW'(10'h100 + i), 4'b0000);
      push_one("t3_pp", 1, 10'h0AA, 4'b0010);
      check("t3_count", 32'(io.count[1]), 32'd16);
      check("t3_nodrop", 32'(io.drop_cnt[1]), 32'd0);
      for (int i = 0; i < 16; i++) idle("t3_drain", 4'b0010);

      // 4: all queues pushed together while q3 streams
      ptrs = {10'h040, 10'h030, 10'h020, 10'h010};
      step("t4_all", 4'b1111, ptrs, 4'b1000);
      for (int i = 0; i < 6; i++) begin
         ptrs = '0;
         ptrs[3] = AW'(10'h041 + i);
         step("t4_q3", 4'b1000, ptrs, 4'b1000);
         check("t4_q0cnt", 32'(io.count[0]), 32'd1);
      end
      for (int i = 0; i < 3; i++) idle("t4_drain", 4'b1111);

      // 5: continuous streaming through q0, both pointers wrap
      for (int i = 0; i < 40; i++) begin
         push_one("t5_stream", 0, AW'(10'h200 + i), 4'b0001);
         check("t5_cnt_le2", 32'(io.count[0] <= 2), 32'd1);
      end
      idle("t5_drain", 4'b0001);

      // Random traffic, biased toward filling so drops and wraps occur
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < NP; p++) begin
            ptrs[p] = AW'($urandom_range(0, 1023));
            req[p]  = ($urandom_range(0, 3) != 0);
            rdy[p]  = ($urandom_range(0, 2) == 0);
         end
         step("rand", req, ptrs, rdy);
      end

      // 6: drop counter saturation, then asynchronous reset mid-stream
      for (int i = 0; i < 40; i++) push_one("t6_sat", 1, AW'(10'h300 + i), 4'b0000);
      check("t6_satval", 32'(io.drop_cnt[1]), 32'hF);
      @(negedge clk);
      io.voq_write_reqs = 4'b1111;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all("t6_rst");
      check("t6_rst_valid", 32'(io.head_valid), 32'd0);
      @(negedge clk);
      io.voq_write_reqs = '0;
      rst_n = 1'b1;
      push_one("t6_after", 3, 10'h3C3, 4'b0000);
      check("t6_after_head", 32'(io.head_ptr[3]), 32'h3C3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end
endmodule
`default_nettype wire
